lfsr_checker: RTL

//  Receive-side partner of the team's Fibonacci LFSR generator: takes the serial

---
 rtl/lfsr_pkg.sv | 18 +
 rtl/lfsr_step.sv | 15 +
 rtl/lfsr_checker.sv | 136 +++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the Fibonacci LFSR generator/checker pair:
// state encoding, default tap mask and the feedback function.
package lfsr_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } lfsr_state_e;

    // x^4 + x^3 + 1
    localparam logic [3:0] TAPS_4 = 4'b1100;

    // Operands are zero-extended by the caller, so LFSRs up to 32 bits are supported.
    function automatic logic lfsr_fb(input logic [31:0] s, input logic [31:0] taps);
        return ^(s & taps);
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational next-bit predictor: XOR of the tapped state bits.
// Identical to the generator's feedback, so both ends agree on the sequence.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_4)
) (
    input  logic [WIDTH-1:0] s_i,
    output logic             p_o
);

    assign p_o = lfsr_fb(32'(s_i), 32'(TAPS));

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-seeds from the line, locks after a run of
// correct predictions, then counts mismatches against a free-running copy.
// Optional LFSR_CHK_STATS_EN adds a 32-bit count of bits checked while locked.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(TAPS_4),
    parameter int               LOCK_COUNT = 8,
    parameter int               ERR_THRESH = 4,
    parameter int               CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_count,
    output logic             locked,
    output logic             err_pulse,
    output logic             sync_loss,
    output logic [CNT_W-1:0] err_count
`ifdef LFSR_CHK_STATS_EN
    ,
    output logic [31:0]      bit_count
`endif
);

    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(ERR_THRESH + 1);

    lfsr_state_e        state_q;
    logic [WIDTH-1:0]   s_q;
    logic [FILL_W-1:0]  fill_q;
    logic [MATCH_W-1:0] match_q;
    logic [MISS_W-1:0]  miss_q;
    logic               locked_q;
    logic               err_pulse_q;
    logic               sync_loss_q;
    logic [CNT_W-1:0]   err_count_q;
    logic [CNT_W-1:0]   err_count_d;
    logic               p;
`ifdef LFSR_CHK_STATS_EN
    logic [31:0]        bit_count_q;
`endif

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .s_i (s_q),
        .p_o (p)
    );

    assign err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEARCH;
            s_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            sync_loss_q <= 1'b0;
            err_count_q <= '0;
`ifdef LFSR_CHK_STATS_EN
            bit_count_q <= '0;
`endif
        end else begin
            err_pulse_q <= 1'b0;
            sync_loss_q <= 1'b0;
            if (in_valid) begin
                case (state_q)
                    SEARCH: begin
                        s_q <= {s_q[WIDTH-2:0], in_bit};
                        if (fill_q != FILL_W'(WIDTH)) begin
                            fill_q <= fill_q + 1'b1;
                        end else if (in_bit == p && s_q != '0) begin
                            if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                match_q  <= '0;
                            end else begin
                                match_q <= match_q + 1'b1;
                            end
                        end else begin
                            // An all-zero state predicts zeros forever; never let it lock.
                            match_q <= '0;
                        end
                    end
                    LOCKED: begin
                        s_q <= {s_q[WIDTH-2:0], p};
`ifdef LFSR_CHK_STATS_EN
                        bit_count_q <= bit_count_q + 32'd1;
`endif
                        if (in_bit != p) begin
                            err_pulse_q <= 1'b1;
                            err_count_q <= err_count_d;
                            if (miss_q == MISS_W'(ERR_THRESH - 1)) begin
                                state_q     <= SEARCH;
                                locked_q    <= 1'b0;
                                sync_loss_q <= 1'b1;
                                fill_q      <= '0;
                                match_q     <= '0;
                                miss_q      <= '0;
                            end else begin
                                miss_q <= miss_q + 1'b1;
                            end
                        end else begin
                            miss_q <= '0;
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
            end
            // A clear takes priority over an increment landing on the same edge.
            if (clr_count) begin
                err_count_q <= '0;
`ifdef LFSR_CHK_STATS_EN
                bit_count_q <= '0;
`endif
            end
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign sync_loss = sync_loss_q;
    assign err_count = err_count_q;
`ifdef LFSR_CHK_STATS_EN
    assign bit_count = bit_count_q;
`endif

endmodule
